// File: rtl/button_conditioner.sv
// Conditions five raw front-panel inputs: synchronises, debounces on a 1 kHz tick,
// makes start/stop/increment pulses and auto-repeats the increment buttons.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk1k,
  input  logic en,
  input  logic start_btn,
  input  logic stop_btn,
  input  logic softrst_sw,
  input  logic inc_min_btn,
  input  logic inc_sec_btn,
  output logic start,
  output logic stop,
  output logic softrst,
  output logic inc_min,
  output logic inc_sec
);

  localparam int unsigned ChStart = 0;
  localparam int unsigned ChStop  = 1;
  localparam int unsigned ChSoft  = 2;
  localparam int unsigned ChMin   = 3;
  localparam int unsigned ChSec   = 4;

  localparam logic [3:0] DbLimit   = DEBOUNCE_MS[3:0];
  localparam logic [9:0] DelayLoad = REPEAT_DELAY_MS[9:0];
  localparam logic [9:0] RateLoad  = REPEAT_RATE_MS[9:0];

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

  // clk1k: two sync flops plus one history flop for edge detection
  logic [2:0] ck_q;
  logic       tick;
  assign tick = ck_q[1] & ~ck_q[2];

  logic [4:0] raw;
  logic [4:0] sync1_q, sync2_q;
  logic [4:0] stable_q, stable_d;
  logic [3:0] db_cnt_q [5];
  logic [3:0] db_cnt_d [5];

  assign raw = {inc_sec_btn, inc_min_btn, softrst_sw, stop_btn, start_btn};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 5; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick) begin
        if (db_cnt_q[i] + 4'd1 == DbLimit) begin
          stable_d[i] = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Edge detection on the pulse-producing channels: {sec, min, stop, start}
  logic [3:0] edge_cur, edge_prev_q, rise;
  assign edge_cur = {stable_q[ChSec], stable_q[ChMin], stable_q[ChStop], stable_q[ChStart]};
  assign rise     = edge_cur & ~edge_prev_q;

  rep_state_e state_q [2];
  rep_state_e state_d [2];
  logic [9:0] rep_cnt_q [2];
  logic [9:0] rep_cnt_d [2];
  logic [1:0] inc_pulse;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]   = state_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      inc_pulse[i] = 1'b0;
      if (edge_prev_q[2+i] && !edge_cur[2+i]) begin
        state_d[i]   = StIdle;
        rep_cnt_d[i] = '0;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (rise[2+i]) begin
              inc_pulse[i] = 1'b1;
              rep_cnt_d[i] = DelayLoad;
              state_d[i]   = StDelay;
            end
          end
          StDelay, StRepeat: begin
            if (tick) begin
              // Counter hits zero on this tick: pulse and reload the repeat interval
              if (rep_cnt_q[i] == 10'd1) begin
                inc_pulse[i] = 1'b1;
                rep_cnt_d[i] = RateLoad;
                state_d[i]   = StRepeat;
              end else begin
                rep_cnt_d[i] = rep_cnt_q[i] - 10'd1;
              end
            end
          end
          default: state_d[i] = StIdle;
        endcase
      end
    end
  end

  logic start_q, stop_q, inc_min_q, inc_sec_q;
  logic start_d, stop_d, inc_min_d, inc_sec_d;

  always_comb begin
    stop_d    = en & rise[1];
    start_d   = en & rise[0] & ~rise[1];
    inc_min_d = en & inc_pulse[0];
    inc_sec_d = en & inc_pulse[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_q        <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      edge_prev_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i]   <= StIdle;
        rep_cnt_q[i] <= '0;
      end
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      inc_min_q <= 1'b0;
      inc_sec_q <= 1'b0;
    end else begin
      ck_q        <= {ck_q[1:0], clk1k};
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      edge_prev_q <= edge_cur;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int i = 0; i < 2; i++) begin
        state_q[i]   <= state_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
      start_q   <= start_d;
      stop_q    <= stop_d;
      inc_min_q <= inc_min_d;
      inc_sec_q <= inc_sec_d;
    end
  end

  assign start   = start_q;
  assign stop    = stop_q;
  assign inc_min = inc_min_q;
  assign inc_sec = inc_sec_q;
  assign softrst = stable_q[ChSoft];

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: event-level reference model compared
// every cycle, directed scenarios with literal pulse counts, then random stimulus.
module tb_button_conditioner;

  localparam int unsigned DB   = 4;
  localparam int unsigned DLY  = 20;
  localparam int unsigned RATE = 5;
  localparam int unsigned TCLK = 10;  // clk cycles per 1 kHz period in simulation

  logic clk = 1'b0, rst_n = 1'b0, clk1k = 1'b0, en = 1'b1;
  logic start_btn = 1'b0, stop_btn = 1'b0, softrst_sw = 1'b0;
  logic inc_min_btn = 1'b0, inc_sec_btn = 1'b0;
  logic start, stop, softrst, inc_min, inc_sec;

  button_conditioner #(
    .DEBOUNCE_MS    (DB),
    .REPEAT_DELAY_MS(DLY),
    .REPEAT_RATE_MS (RATE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk1k      (clk1k),
    .en         (en),
    .start_btn  (start_btn),
    .stop_btn   (stop_btn),
    .softrst_sw (softrst_sw),
    .inc_min_btn(inc_min_btn),
    .inc_sec_btn(inc_sec_btn),
    .start      (start),
    .stop       (stop),
    .softrst    (softrst),
    .inc_min    (inc_min),
    .inc_sec    (inc_sec)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: raw inputs seen two clocks late, accepted after DB ticks of
  // disagreement, acceptance events turn into pulses one clock later; increment
  // pulses come from the number of ticks elapsed since the accepted press.
  bit [2:0] m_ck;
  bit [4:0] m_s1, m_s2, m_acc, m_rise_ev, m_fall_ev;
  int       m_run [5];
  bit       m_held [2];
  int       m_t [2];
  bit       exp_start, exp_stop, exp_min, exp_sec;

  task automatic model_reset();
    m_ck = '0; m_s1 = '0; m_s2 = '0; m_acc = '0; m_rise_ev = '0; m_fall_ev = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    for (int i = 0; i < 2; i++) begin m_held[i] = 0; m_t[i] = 0; end
    exp_start = 0; exp_stop = 0; exp_min = 0; exp_sec = 0;
  endtask

  task automatic model_step();
    bit       tk;
    bit [4:0] raw;
    bit [1:0] pulse;
    tk  = m_ck[1] & ~m_ck[2];
    raw = {inc_sec_btn, inc_min_btn, softrst_sw, stop_btn, start_btn};
    exp_stop  = en & m_rise_ev[1];
    exp_start = en & m_rise_ev[0] & ~m_rise_ev[1];
    for (int i = 0; i < 2; i++) begin
      pulse[i] = 0;
      if (m_rise_ev[3+i]) begin
        m_held[i] = 1; m_t[i] = 0; pulse[i] = 1;
      end else if (m_fall_ev[3+i]) begin
        m_held[i] = 0;
      end else if (m_held[i] && tk) begin
        m_t[i]++;
        pulse[i] = (m_t[i] == DLY) || (m_t[i] > DLY && (m_t[i] - DLY) % RATE == 0);
      end
    end
    exp_min = en & pulse[0];
    exp_sec = en & pulse[1];
    m_rise_ev = '0;
    m_fall_ev = '0;
    for (int c = 0; c < 5; c++) begin
      if (m_s2[c] != m_acc[c]) begin
        if (tk) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_acc[c] = m_s2[c];
            m_run[c] = 0;
            if (m_s2[c]) m_rise_ev[c] = 1; else m_fall_ev[c] = 1;
          end
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_ck = {m_ck[1:0], clk1k};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  int c_start = 0, c_stop = 0, c_min = 0, c_sec = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("start", start, exp_start);
      check("stop", stop, exp_stop);
      check("inc_min", inc_min, exp_min);
      check("inc_sec", inc_sec, exp_sec);
      check("softrst", softrst, m_acc[2]);
      if (start === 1'b1) c_start++;
      if (stop === 1'b1) c_stop++;
      if (inc_min === 1'b1) c_min++;
      if (inc_sec === 1'b1) c_sec++;
    end
  end

  // 1 kHz square wave, TCLK clk cycles per period
  initial begin
    int div = 0;
    forever begin
      @(posedge clk);
      #2;
      div   = (div + 1) % TCLK;
      clk1k = (div < TCLK / 2);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr_counts();
    c_start = 0; c_stop = 0; c_min = 0; c_sec = 0;
  endtask

  initial begin
    wait_clk(5);
    check("reset_outputs", {start, stop, softrst, inc_min, inc_sec}, 0);
    rst_n = 1'b1;
    wait_clk(20);

    // Bounce on start_btn
    clr_counts();
    start_btn = 1; wait_clk(TCLK);
    start_btn = 0; wait_clk(TCLK);
    check("bounce_quiet", c_start, 0);
    start_btn = 1; wait_clk(60);
    check("bounce_latency", c_start, 1);
    wait_clk(40);
    start_btn = 0; wait_clk(80);
    check("bounce_pulses", c_start, 1);

    // Auto-repeat on inc_sec
    clr_counts();
    inc_sec_btn = 1; wait_clk(385);
    inc_sec_btn = 0; wait_clk(100);
    check("repeat_sec_count", c_sec, 5);
    check("repeat_min_quiet", c_min, 0);

    // Simultaneous start/stop
    clr_counts();
    start_btn = 1; stop_btn = 1; wait_clk(100);
    check("simul_stop", c_stop, 1);
    check("simul_start", c_start, 0);
    start_btn = 0; stop_btn = 0; wait_clk(80);
    check("simul_release", c_start + c_stop, 1);

    // en gating across the first two inc_min pulses
    clr_counts();
    en = 0; inc_min_btn = 1; softrst_sw = 1; wait_clk(250);
    check("gate_quiet", c_min, 0);
    check("gate_softrst_hi", softrst, 1);
    en = 1; wait_clk(135);
    inc_min_btn = 0; softrst_sw = 0; wait_clk(100);
    check("gate_later_pulses", c_min, 3);
    check("gate_softrst_lo", softrst, 0);

    // Reset while inc_min is in REPEAT, button still held
    clr_counts();
    inc_min_btn = 1; wait_clk(300);
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      check("rst_mid_outputs", {start, stop, softrst, inc_min, inc_sec}, 0);
      wait_clk(1);
    end
    rst_n = 1;
    clr_counts();
    wait_clk(100);
    check("rst_first_pulse", c_min, 1);
    wait_clk(150);
    check("rst_delay_restart", c_min, 2);
    inc_min_btn = 0; wait_clk(100);

    // softrst glitch filtering
    softrst_sw = 1; wait_clk(30);
    softrst_sw = 0; wait_clk(60);
    check("glitch_short", softrst, 0);
    softrst_sw = 1; wait_clk(50);
    check("glitch_long_hi", softrst, 1);
    softrst_sw = 0; wait_clk(25);
    check("glitch_hold_hi", softrst, 1);
    wait_clk(30);
    check("glitch_release", softrst, 0);

    // Random traffic on every input, checked by the model each cycle
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 59) == 0) start_btn   = ~start_btn;
      if ($urandom_range(0, 59) == 0) stop_btn    = ~stop_btn;
      if ($urandom_range(0, 59) == 0) softrst_sw  = ~softrst_sw;
      if ($urandom_range(0, 79) == 0) inc_min_btn = ~inc_min_btn;
      if ($urandom_range(0, 79) == 0) inc_sec_btn = ~inc_sec_btn;
      if ($urandom_range(0, 299) == 0) en = ~en;
      rst_n = ($urandom_range(0, 1999) != 0);
      wait_clk(1);
    end
    rst_n = 1; en = 1;
    start_btn = 0; stop_btn = 0; softrst_sw = 0; inc_min_btn = 0; inc_sec_btn = 0;
    wait_clk(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
